// File: rtl/box_filter_pkg.sv
// Shared widths, divider constants and border-mode type
// for the KxK box filter.
package box_filter_pkg;

    typedef enum logic {
        BM_VALID = 1'b0,
        BM_ZERO  = 1'b1
    } border_mode_e;

    localparam int DIV_RECIP_PAD = 2;

    function automatic int col_w(input int pw, input int k);
        return pw + $clog2(k);
    endfunction

    function automatic int win_w(input int pw, input int k);
        return pw + 2 * $clog2(k);
    endfunction

    function automatic int kk(input int k);
        return k * k;
    endfunction

    function automatic int radius(input int k);
        return (k - 1) / 2;
    endfunction

    // numerator is win + K*K/2, one bit wider than the window sum
    function automatic int div_in_w(input int pw, input int k);
        return win_w(pw, k) + 1;
    endfunction

    // with recip = ceil(2^shift / d) and shift = N + ceil(log2 d),
    // (x * recip) >> shift == floor(x / d) for every x < 2^N
    function automatic int div_shift(input int pw, input int k);
        return div_in_w(pw, k) + $clog2(kk(k));
    endfunction

    function automatic logic [63:0] div_recip(input int pw, input int k);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'd1 << div_shift(pw, k);
        den = 64'(kk(k));
        return (num + den - 64'd1) / den;
    endfunction

endpackage

// File: rtl/box_div_round.sv
// Exact round-half-up divide of a window sum by K*K,
// one register stage, reciprocal multiply and shift.
module box_div_round
    import box_filter_pkg::*;
#(
    parameter int K           = 3,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             arst,
    input  logic [win_w(PIXEL_WIDTH, K)-1:0] win,
    output logic [PIXEL_WIDTH-1:0]           q
);

    localparam int IW = div_in_w(PIXEL_WIDTH, K);
    localparam int RW = IW + DIV_RECIP_PAD;
    localparam int PW = IW + RW;
    localparam int SH = div_shift(PIXEL_WIDTH, K);
    localparam logic [RW-1:0] RECIP = RW'(div_recip(PIXEL_WIDTH, K));
    localparam logic [IW-1:0] BIAS  = IW'(kk(K) / 2);

    logic [IW-1:0] num;
    logic [PW-1:0] prod;

    assign num  = IW'(win) + BIAS;
    assign prod = PW'(num) * PW'(RECIP);

    // register the quotient; it always fits the pixel width
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            q <= '0;
        end else begin
            q <= PIXEL_WIDTH'(prod >> SH);
        end
    end

endmodule

// File: rtl/box_filter_kxk.sv
// KxK box filter: column sum, running window sum, rounded
// divide, with valid-only or zero-pad row borders.
module box_filter_kxk
    import box_filter_pkg::*;
#(
    parameter int K           = 3,
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int IMAGE_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              arst,
    input  logic                              border_mode,
    input  logic [CHANNELS*K*PIXEL_WIDTH-1:0] din,
    input  logic                              din_valid,
    output logic                              din_ready,
    output logic [CHANNELS*PIXEL_WIDTH-1:0]   dout,
    output logic                              dout_valid
);

    localparam int CW = col_w(PIXEL_WIDTH, K);
    localparam int WW = win_w(PIXEL_WIDTH, K);
    localparam int R  = radius(K);
    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int FW = $clog2(R + 1);
    localparam logic [XW-1:0] LAST_COL    = XW'(IMAGE_WIDTH - 1);
    localparam logic [XW-1:0] FIRST_VALID = XW'(K - 1);
    localparam logic [XW-1:0] FIRST_ZERO  = XW'(R);

    logic [XW-1:0]          col;
    logic [FW-1:0]          flush_cnt;
    border_mode_e           mode_q;
    border_mode_e           cur_mode;
    logic                   accept;
    logic                   inject;
    logic                   row_start;
    logic                   last_col;
    logic                   emit;
    logic [CW-1:0]          csum  [CHANNELS];
    logic [CW-1:0]          csum1 [CHANNELS];
    logic                   v1;
    logic                   e1;
    logic                   st1;
    logic [CW-1:0]          sr    [CHANNELS][K];
    logic [WW-1:0]          win   [CHANNELS];
    logic                   v2;
    logic                   v3;
    logic [PIXEL_WIDTH-1:0] q     [CHANNELS];

    assign din_ready = (flush_cnt == '0);
    assign inject    = !din_ready;
    assign accept    = din_valid && din_ready;
    assign row_start = (col == '0);
    assign last_col  = (col == LAST_COL);
    assign cur_mode  = row_start ? border_mode_e'(border_mode) : mode_q;

    // decide whether this accept or inject produces an output pixel
    always_comb begin
        emit = inject;
        if (accept) begin
            if (cur_mode == BM_ZERO) begin
                emit = (col >= FIRST_ZERO);
            end else begin
                emit = (col >= FIRST_VALID);
            end
        end
    end

    // column counter, latched border mode and end-of-row flush count
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            col       <= '0;
            flush_cnt <= '0;
            mode_q    <= BM_VALID;
        end else if (accept) begin
            col <= last_col ? '0 : col + 1'b1;
            if (row_start) begin
                mode_q <= cur_mode;
            end
            if (last_col && cur_mode == BM_ZERO) begin
                flush_cnt <= FW'(R);
            end
        end else if (inject) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    // per-channel sum of the K vertically aligned pixels
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            csum[c] = '0;
            for (int i = 0; i < K; i++) begin
                csum[c] = csum[c]
                    + CW'(din[(c*K+i)*PIXEL_WIDTH +: PIXEL_WIDTH]);
            end
        end
    end

    // stage 1: register column sums; injected columns are all zero
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v1  <= 1'b0;
            e1  <= 1'b0;
            st1 <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                csum1[c] <= '0;
            end
        end else begin
            v1  <= accept || inject;
            e1  <= emit;
            st1 <= accept && row_start;
            for (int c = 0; c < CHANNELS; c++) begin
                csum1[c] <= inject ? '0 : csum[c];
            end
        end
    end

    // stage 2: K-deep column history and running window sum
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v2 <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                win[c] <= '0;
                for (int i = 0; i < K; i++) begin
                    sr[c][i] <= '0;
                end
            end
        end else begin
            v2 <= v1 && e1;
            if (v1) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    win[c] <= st1 ? WW'(csum1[c])
                        : win[c] + WW'(csum1[c]) - WW'(sr[c][K-1]);
                    sr[c][0] <= csum1[c];
                    for (int i = 1; i < K; i++) begin
                        sr[c][i] <= st1 ? '0 : sr[c][i-1];
                    end
                end
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_div
        box_div_round #(
            .K           (K),
            .PIXEL_WIDTH (PIXEL_WIDTH)
        ) u_div (
            .clk  (clk),
            .arst (arst),
            .win  (win[c]),
            .q    (q[c])
        );
    end

    // stage 3 valid delay and output register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            v3         <= 1'b0;
            dout_valid <= 1'b0;
            dout       <= '0;
        end else begin
            v3         <= v2;
            dout_valid <= v3;
            if (v3) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    dout[c*PIXEL_WIDTH +: PIXEL_WIDTH] <= q[c];
                end
            end
        end
    end

endmodule

// File: doc/box_filter_kxk.md
Name: box_filter_kxk

Overview:
- Parametrised successor to the fixed 3x3 averager; consumes K vertically aligned pixels per column from the line aligner and emits the rounded KxK mean per channel.
- Adds runtime-selectable border mode (valid-only or zero-pad) with a din_ready flush handshake.
- Adds multi-channel packing and exact round-half-up division.
- Sits between the line aligner and downstream capture/op stages in the image pipeline.

Parameters:
- K, 3, kernel size (odd, 3..7); also the number of aligned lines per input column
- PIXEL_WIDTH, 8, bits per pixel per channel
- CHANNELS, 1, independent channels packed side by side (1..4)
- IMAGE_WIDTH, 128, pixels per row; sets the column counter wrap

Ports:
- clk  in  1  system clock
- arst  in  1  asynchronous active-high reset
- border_mode  in  1  0 = valid-only, 1 = zero-pad; sampled only at row start (column 0)
- din  in  CHANNELS*K*PIXEL_WIDTH  aligned column; line i of channel c at bits [(c*K+i)*PIXEL_WIDTH +: PIXEL_WIDTH]
- din_valid  in  1  column valid
- din_ready  out  1  block can accept a column; low only during zero-pad flush
- dout  out  CHANNELS*PIXEL_WIDTH  mean per channel, channel c at [c*PIXEL_WIDTH +: PIXEL_WIDTH]
- dout_valid  out  1  dout valid, single-cycle strobe per output pixel

Behaviour:
- Reset: arst is asynchronous and active-high. It clears all pipeline registers, column counter, flush counter and latched mode.
- Reset values: dout = 0, dout_valid = 0, din_ready = 1. A mid-row reset discards the partial row; the next accepted column is treated as column 0.
- Input acceptance: a column is accepted when din_valid && din_ready. A column presented while din_ready = 0 is ignored and not stored; the upstream block holds it.
- Stage 1 (column sum): per channel, sum of K pixels, width CW = PIXEL_WIDTH + clog2(K).
- Stage 2 (window sum):
  - K-deep shift register of column sums per channel.
  - Running window sum updated as sum + new - oldest; width WW = PIXEL_WIDTH + 2*clog2(K).
  - The shift register and running sum clear to zero at row start.
- Stage 3 (divide): out = floor((win + (K*K)/2) / (K*K)).
  - The implementation must be bit-exact for all win in 0..K*K*(2^PIXEL_WIDTH - 1).
  - A constant reciprocal multiply with a proven shift is allowed. The result always fits PIXEL_WIDTH.
- Column counter: counts accepted columns 0..IMAGE_WIDTH-1, wraps to 0 after the last column. border_mode is latched when column 0 is accepted.
- Valid-only mode:
  - Output for accepted column j when j >= K-1, i.e. IMAGE_WIDTH-K+1 outputs per row.
  - Latency: dout_valid is high 3 cycles after the accepting clock edge.
  - No flush; din_ready stays 1.
- Zero-pad mode (R = (K-1)/2):
  - Output centred on column j - R is emitted for accepted column j >= R.
  - After column IMAGE_WIDTH-1 is accepted, the block drives din_ready = 0 for exactly R cycles. Each of these cycles injects an all-zero column internally, producing the last R outputs.
  - Gives IMAGE_WIDTH outputs per row; latency 3 cycles per accept or inject.
  - din_ready returns to 1 on the cycle after the last injection.
- Throughput: no bubbles except the flush, so back-to-back rows are sustained.
- Gaps: din_valid gaps are permitted anywhere. The pipeline advances only on accept or inject, and dout_valid follows exactly.
- Channels: all channels share control and are computed identically in parallel.

Decomposition:
- Package box_filter_pkg holds:
  - functions for CW, WW, K*K and R;
  - the reciprocal constant and shift for the divider;
  - the enum border_mode_e {BM_VALID, BM_ZERO}.
- One sub-module is natural: box_div_round, a pipelined (1-stage) exact divide-by-K*K with round-half-up, instantiated per channel.

Test Plan:
- Ramp, valid-only: K=3, W=128, every row 1..128 on all K lines, border_mode=0 → 126 outputs per row with values 2..127; dout_valid first rises 3 cycles after the accept of column 2.
- Ramp, zero-pad: same stimulus, border_mode=1 → 128 outputs per row.
  - First output: (0+1+2)*3/9 = 1; last output: (127+128+0)*3/9 = 85.
  - din_ready is low for exactly 1 cycle after column 127.
- Saturation and rounding: all pixels 255 in valid-only mode → every output 255. One window with sum 13 (K=3) → 1; sum 14 → 2 (half-up).
- Gapped input: random din_valid duty 50%, ramp input → output value sequence identical to the first scenario; dout_valid count per row = 126.
- Reset mid-row: assert arst for 2 cycles after column 60 → dout_valid = 0 and din_ready = 1 immediately. The next row restarts at column 0 with correct values 2..127.
- Multi-channel: CHANNELS=3, K=5, ch0 constant 10, ch1 ramp, ch2 constant 0 → ch0 = 10, ch1 = ramp mean (column j ≥ 4 → j-1), ch2 = 0, all in the same output cycle.
